// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared scan states, blank code and sizing helper for the digit scan controller
package seg_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_ON    = 1'b1
  } seg_state_t;

  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int         DEF_N_DIG  = 4;

  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - write port and display outputs of the digit scan controller
interface seg_scan_ctrl_if import seg_pkg::*; #(
  parameter int N_DIG = DEF_N_DIG
);

  logic               WR_EN;
  logic [4*N_DIG-1:0] WR_DATA;
  logic               LZ_EN;
  logic [3:0]         D;
  logic [N_DIG-1:0]   AN;
  logic               FRAME;
  logic               PEND;

  modport master (
    output WR_EN, WR_DATA, LZ_EN,
    input  D, AN, FRAME, PEND
  );

  modport slave (
    input  WR_EN, WR_DATA, LZ_EN,
    output D, AN, FRAME, PEND
  );

endinterface

// File: rtl/seg_tick_cnt.sv
// rtl/seg_tick_cnt.sv - loadable up-counter flagging the cycle its count equals a terminal value
module seg_tick_cnt import seg_pkg::*; #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_term,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  assign o_done = (r_cnt == i_term);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_load) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed digit scanner with blanking gaps and frame-aligned data commit
module seg_scan_ctrl import seg_pkg::*; #(
  parameter int N_DIG     = DEF_N_DIG,
  parameter int ON_CYC    = 50000,
  parameter int BLANK_CYC = 16
) (
  input logic            CLK,
  input logic            RST,
  seg_scan_ctrl_if.slave bus
);

  localparam int               CNT_W      = cnt_width(ON_CYC, BLANK_CYC);
  localparam int               IDX_W      = $clog2(N_DIG);
  localparam logic [CNT_W-1:0] ON_TERM    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIG - 1);

  seg_state_t         r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [4*N_DIG-1:0] r_active;
  logic [4*N_DIG-1:0] r_pending;
  logic               r_pend;
  logic               r_frame;
  logic [3:0]         r_d;
  logic [N_DIG-1:0]   r_an;

  logic               w_done;
  logic               w_wrap;
  logic [CNT_W-1:0]   w_term;
  logic [N_DIG-1:0]   w_zero_from;
  logic [3:0]         w_code;

  assign w_term = (r_state == S_BLANK) ? BLANK_TERM : ON_TERM;
  assign w_wrap = (r_state == S_ON) && w_done && (r_idx == LAST_IDX);

  seg_tick_cnt #(.W(CNT_W)) u_tick (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_load (w_done),
    .i_term (w_term),
    .o_done (w_done)
  );

  // w_zero_from[i] is set when nibbles N_DIG-1 down to i of the shown value are all zero
  always_comb begin : lz_scan
    logic v_zero;
    v_zero      = 1'b1;
    w_zero_from = '0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      v_zero         = v_zero && (r_active[4*i +: 4] == 4'd0);
      w_zero_from[i] = v_zero;
    end
  end

  assign w_code = (bus.LZ_EN && (r_idx != '0) && w_zero_from[r_idx]) ? BLANK_CODE
                                                                      : r_active[4*r_idx +: 4];

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_BLANK;
      r_idx     <= '0;
      r_an      <= '1;
      r_d       <= BLANK_CODE;
      r_frame   <= 1'b0;
      r_pend    <= 1'b0;
      r_active  <= '0;
      r_pending <= '0;
    end else begin
      r_frame <= 1'b0;
      case (r_state)
        S_BLANK: begin
          // D is reloaded throughout the gap so it is stable before the anode turns on
          r_d <= w_code;
          if (w_done) begin
            r_state <= S_ON;
            r_an    <= ~(N_DIG'(1) << r_idx);
          end
        end
        S_ON: begin
          if (w_done) begin
            r_state <= S_BLANK;
            r_an    <= '1;
            r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_BLANK;
      endcase

      if (w_wrap && (bus.WR_EN || r_pend)) begin
        r_active <= bus.WR_EN ? bus.WR_DATA : r_pending;
        r_pend   <= 1'b0;
        r_frame  <= 1'b1;
      end else if (bus.WR_EN) begin
        r_pending <= bus.WR_DATA;
        r_pend    <= 1'b1;
      end
    end
  end

  assign bus.D     = r_d;
  assign bus.AN    = r_an;
  assign bus.FRAME = r_frame;
  assign bus.PEND  = r_pend;

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter N_DIG, default 4, number of multiplexed digits (2..8).
REQ-002 Parameter ON_CYC, default 50000, anode-on cycles per digit (>= 2).
REQ-003 Parameter BLANK_CYC, default 16, all-anodes-off cycles between digits (>= 2).
REQ-004 Port CLK, input, 1, single system clock; all logic on rising edge.
REQ-005 Port RST, input, 1, reset; synchronous and active-high.
REQ-006 Port WR_EN, input, 1, one-cycle strobe; captures WR_DATA.
REQ-007 Port WR_DATA, input, 4*N_DIG, BCD digits; nibble i feeds digit i, nibble 0 least significant.
REQ-008 Port LZ_EN, input, 1, leading-zero blanking enable (level).
REQ-009 Port D, output, 4, registered digit code to the svn_seg decoder D input; 4'hF is the blank code.
REQ-010 Port AN, output, N_DIG, registered digit anodes, active-low.
REQ-011 Port FRAME, output, 1, one-cycle pulse on each frame-boundary commit.
REQ-012 Port PEND, output, 1, high while a written value awaits commit.

Function
REQ-013 The FSM SHALL have two states: S_BLANK (AN all ones) and S_ON (AN[idx] low, all others high).
REQ-014 In S_BLANK, the block SHALL drive D with the code of digit idx, so the registered decoder output settles before S_ON.
REQ-015 S_BLANK SHALL last exactly BLANK_CYC cycles, then go to S_ON with cnt=0.
REQ-016 S_ON SHALL last exactly ON_CYC cycles, then go to S_BLANK with idx=idx+1, wrapping from N_DIG-1 to 0.
REQ-017 The frame period SHALL be N_DIG*(ON_CYC+BLANK_CYC) cycles.
REQ-018 Anodes SHALL never be low in two digits in the same cycle, and AN SHALL never move directly from one low digit to another.
REQ-019 WR_EN SHALL load the pending register and set PEND; a later WR_EN before commit SHALL overwrite it (last write wins).
REQ-020 Commit SHALL occur on the S_ON->S_BLANK transition where idx wraps to 0; if PEND=1, active<=pending, PEND<=0, and FRAME=1 for that one cycle.
REQ-021 If WR_EN coincides with the commit cycle, WR_DATA SHALL be committed directly, PEND SHALL end 0, and FRAME SHALL pulse.
REQ-022 Displayed digits SHALL come only from the active register, so no frame ever shows a mix of old and new data.
REQ-023 When LZ_EN=1, digit i (i>0) SHALL output 4'hF if active nibbles N_DIG-1..i are all zero; digit 0 SHALL always show its value.
REQ-024 Nibbles above 9 SHALL pass through unchanged; the decoder blanks them.
REQ-025 Counters SHALL be sized $clog2(max(ON_CYC,BLANK_CYC)) and compare against terminal-1; wrap SHALL never depend on overflow.

Reset
REQ-026 RST SHALL override all other inputs in the cycle it is sampled high.
REQ-027 The reset state SHALL be: state=S_BLANK, idx=0, cnt=0, AN=all ones, D=4'hF, FRAME=0, PEND=0, active=0, pending=0.
REQ-028 RST asserted mid-frame SHALL discard any pending data, and scanning SHALL restart at digit 0 with a full BLANK_CYC interval.

Structure
REQ-029 The state enum, blank code 4'hF and the default N_DIG SHALL live in shared package seg_pkg.
REQ-030 The block SHALL contain a single sub-module, seg_tick_cnt (a loadable terminal-count counter), used for both S_BLANK and S_ON timing.
REQ-031 The decoder SHALL be instantiated outside this block at top level; this block SHALL NOT contain it.

Verification (N_DIG=4, ON_CYC=8, BLANK_CYC=2)
REQ-032 Release RST -> AN=4'hF for 2 cycles, then AN=4'b1110 for 8 cycles, then AN=4'hF for 2 cycles, then AN=4'b1101; frame period = 40 cycles.
REQ-033 WR_DATA=16'h1234 written mid-frame -> PEND=1 immediately; the current frame shows old data; D=4,3,2,1 appears only after the FRAME pulse, and PEND=0 then.
REQ-034 Two writes (16'h1111 then 16'h2222) in one frame -> only 2222 is displayed; one FRAME pulse.
REQ-035 WR_EN with 16'h5678 on the commit cycle -> next frame shows 8,7,6,5; PEND stays 0.
REQ-036 LZ_EN=1 with 16'h0040 -> D sequence per frame is 0,4,F,F; with 16'h0000 -> 0,F,F,F.
REQ-037 RST pulsed while AN=4'b1011 -> AN=4'hF and D=4'hF next cycle, PEND=0, scanning restarts at digit 0; assertion that AN is one-hot-low or all-high holds throughout.
